// File: rtl/sdes_pkg.sv
// Shared S-DES key-schedule constants: permutation tables, widths, rotation schedule, FSM states.
// Table entries are 1-based bit positions counted from the MSB of the source word.
package sdes_pkg;

    localparam int KEY_W      = 10;
    localparam int RK_W       = 8;
    localparam int HALF_W     = 5;
    localparam int MAX_ROUNDS = 4;

    localparam int P10_TAB [KEY_W] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_TAB  [RK_W]  = '{6, 3, 7, 4, 8, 5, 10, 9};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        SERVE  = 2'd2
    } state_t;

    // Cumulative left-rotate amount for a round, measured from the P10 word:
    // 1 for round 0, then +2 per round, taken modulo the 5-bit half width.
    function automatic logic [2:0] ROT_SCHED(input logic [1:0] rnd);
        int amt;
        amt = (1 + 2 * int'(rnd)) % HALF_W;
        return 3'(amt);
    endfunction

endpackage

// File: rtl/sdes_key_perm.sv
// Combinational S-DES key helpers: P10 of the master key, and P8 of the rotated P10 word.
// Zero latency; no handshake.
module sdes_key_perm
    import sdes_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [KEY_W-1:0] p10_word_i,
    input  logic [2:0]       rot_i,
    output logic [KEY_W-1:0] p10_o,
    output logic [RK_W-1:0]  rk_o
);

    logic [KEY_W-1:0] rot_word;

    function automatic logic [HALF_W-1:0] rotl5(input logic [HALF_W-1:0] x,
                                                input logic [2:0]        n);
        logic [2*HALF_W-1:0] d;
        d = {x, x} << n;
        return d[2*HALF_W-1:HALF_W];
    endfunction

    always_comb begin
        p10_o = '0;
        for (int i = 0; i < KEY_W; i++) begin
            p10_o[KEY_W-1-i] = key_i[KEY_W-P10_TAB[i]];
        end
    end

    // Halves rotate independently; the high half holds positions 1..5.
    always_comb begin
        rot_word = {rotl5(p10_word_i[KEY_W-1:HALF_W], rot_i),
                    rotl5(p10_word_i[HALF_W-1:0], rot_i)};
    end

    always_comb begin
        rk_o = '0;
        for (int i = 0; i < RK_W; i++) begin
            rk_o[RK_W-1-i] = rot_word[KEY_W-P8_TAB[i]];
        end
    end

endmodule

// File: rtl/sdes_key_schedule.sv
// S-DES round-key generator: expands one key per clock into a buffer, then serves keys in order.
// First key valid NUM_ROUNDS cycles after key_load; holds rk_out stable while rk_ready is low.
module sdes_key_schedule
    import sdes_pkg::*;
#(
    parameter int NUM_ROUNDS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    input  logic             decrypt,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_out,
    output logic [1:0]       rk_idx,
    output logic             rk_last
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_ROUNDS - 1);

    state_t           state_q;
    logic [1:0]       cnt_q;
    logic [1:0]       pos_q;
    logic             dec_q;
    logic [KEY_W-1:0] p10_q;
    logic [RK_W-1:0]  buf_q [MAX_ROUNDS];

    logic             busy_q;
    logic             rk_valid_q;
    logic             rk_last_q;
    logic [RK_W-1:0]  rk_out_q;
    logic [1:0]       rk_idx_q;

    logic [KEY_W-1:0] key_p10;
    logic [RK_W-1:0]  rk_new;
    logic [1:0]       first_idx;
    logic [1:0]       pos_d;
    logic [1:0]       next_idx;
    logic             xfer;

    sdes_key_perm u_perm (
        .key_i      (key_in),
        .p10_word_i (p10_q),
        .rot_i      (ROT_SCHED(cnt_q)),
        .p10_o      (key_p10),
        .rk_o       (rk_new)
    );

    // Serve position counts transfers; the true round index is mirrored for decrypt.
    always_comb begin
        first_idx = dec_q ? LAST_IDX : 2'd0;
        pos_d     = pos_q + 2'd1;
        next_idx  = dec_q ? (LAST_IDX - pos_d) : pos_d;
        xfer      = rk_valid_q & rk_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            pos_q      <= 2'd0;
            dec_q      <= 1'b0;
            p10_q      <= '0;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            rk_out_q   <= '0;
            rk_idx_q   <= 2'd0;
            for (int i = 0; i < MAX_ROUNDS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (key_load) begin
            // A load in any state restarts; a coincident transfer belongs to the old key.
            state_q    <= EXPAND;
            cnt_q      <= 2'd0;
            pos_q      <= 2'd0;
            dec_q      <= decrypt;
            p10_q      <= key_p10;
            busy_q     <= 1'b1;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q     <= 1'b0;
                    rk_valid_q <= 1'b0;
                end
                EXPAND: begin
                    buf_q[cnt_q] <= rk_new;
                    cnt_q        <= cnt_q + 2'd1;
                    if (cnt_q == LAST_IDX) begin
                        // First served key may be the one being written this edge.
                        state_q    <= SERVE;
                        rk_valid_q <= 1'b1;
                        rk_idx_q   <= first_idx;
                        rk_out_q   <= (first_idx == cnt_q) ? rk_new : buf_q[first_idx];
                        rk_last_q  <= (NUM_ROUNDS == 1);
                    end
                end
                SERVE: begin
                    if (xfer) begin
                        if (rk_last_q) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            rk_valid_q <= 1'b0;
                            rk_last_q  <= 1'b0;
                        end else begin
                            pos_q     <= pos_d;
                            rk_idx_q  <= next_idx;
                            rk_out_q  <= buf_q[next_idx];
                            rk_last_q <= (pos_d == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    rk_valid_q <= 1'b0;
                    rk_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_last  = rk_last_q;
    assign rk_out   = rk_out_q;
    assign rk_idx   = rk_idx_q;

endmodule

// File: tb/tb_sdes_key_schedule.sv
// Scoreboard bench for sdes_key_schedule with NUM_ROUNDS = 2 and hand-computed S-DES keys.
module tb_sdes_key_schedule;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_load = 1'b0;
    logic [9:0] key_in = '0;
    logic       decrypt = 1'b0;
    logic       rk_ready = 1'b0;
    logic       busy;
    logic       rk_valid;
    logic [7:0] rk_out;
    logic [1:0] rk_idx;
    logic       rk_last;

    typedef struct packed {
        logic [7:0] k;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;

    localparam logic [9:0] KEY_A = 10'b1010000010;
    localparam logic [7:0] K0_A  = 8'b10100100;
    localparam logic [7:0] K1_A  = 8'b01000011;

    sdes_key_schedule #(.NUM_ROUNDS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_load (key_load),
        .key_in   (key_in),
        .decrypt  (decrypt),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] k, input logic [1:0] idx, input logic last);
        exp_t e;
        e.k = k; e.idx = idx; e.last = last;
        q.push_back(e);
    endtask

    // Returns just after the load edge E0 with key_load already dropped.
    task automatic load(input logic [9:0] k, input logic dec);
        key_load = 1'b1;
        key_in   = k;
        decrypt  = dec;
        tick();
        key_load = 1'b0;
        key_in   = 10'h155;
        decrypt  = ~dec;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && busy; i++) tick();
        chk({name, "_idle"}, int'(busy), 0);
        chk({name, "_drained"}, q.size(), 0);
    endtask

    // Monitor: every accepted key is popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rk_valid && rk_ready) begin
                xfers++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key actual=%0h idx=%0d required=none", rk_out, rk_idx);
                end else begin
                    e = q.pop_front();
                    chk("rk_out", int'(rk_out), int'(e.k));
                    chk("rk_idx", int'(rk_idx), int'(e.idx));
                    chk("rk_last", int'(rk_last), int'(e.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int x0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(rk_valid), 0);
        chk("rst_out", int'(rk_out), 0);
        chk("rst_idx", int'(rk_idx), 0);
        chk("rst_last", int'(rk_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Encrypt order
        rk_ready = 1'b1;
        push(K0_A, 2'd0, 1'b0);
        push(K1_A, 2'd1, 1'b1);
        load(KEY_A, 1'b0);
        chk("enc_busy_e0", int'(busy), 1);
        chk("enc_valid_e0", int'(rk_valid), 0);
        tick();
        chk("enc_valid_e1", int'(rk_valid), 0);
        tick();
        chk("enc_valid_e2", int'(rk_valid), 1);
        tick();
        chk("enc_busy_e3", int'(busy), 1);
        tick();
        chk("enc_busy_e4", int'(busy), 0);
        wait_idle("enc");

        // Decrypt order
        tick();
        push(K1_A, 2'd1, 1'b0);
        push(K0_A, 2'd0, 1'b1);
        load(KEY_A, 1'b1);
        wait_idle("dec");

        // Backpressure
        tick();
        rk_ready = 1'b0;
        push(K0_A, 2'd0, 1'b0);
        push(K1_A, 2'd1, 1'b1);
        load(KEY_A, 1'b0);
        for (int i = 0; i < 20 && !rk_valid; i++) tick();
        chk("bp_valid_seen", int'(rk_valid), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", int'(rk_valid), 1);
            chk("bp_hold_out", int'(rk_out), int'(K0_A));
        end
        x0 = xfers;
        rk_ready = 1'b1;
        wait_idle("bp");
        chk("bp_xfer_count", xfers - x0, 2);

        // Constant keys
        tick();
        push(8'h00, 2'd0, 1'b0);
        push(8'h00, 2'd1, 1'b1);
        load(10'h000, 1'b0);
        wait_idle("zero");
        tick();
        push(8'hFF, 2'd0, 1'b0);
        push(8'hFF, 2'd1, 1'b1);
        load(10'h3FF, 1'b0);
        wait_idle("ones");

        // Reload coinciding with the first transfer
        tick();
        push(K0_A, 2'd0, 1'b0);
        load(KEY_A, 1'b0);
        tick();
        tick();
        chk("rl_first_valid", int'(rk_valid), 1);
        key_load = 1'b1;
        key_in   = 10'h000;
        decrypt  = 1'b0;
        push(8'h00, 2'd0, 1'b0);
        push(8'h00, 2'd1, 1'b1);
        tick();
        key_load = 1'b0;
        key_in   = 10'h2AA;
        chk("rl_valid_drop", int'(rk_valid), 0);
        tick();
        chk("rl_valid_e4", int'(rk_valid), 0);
        tick();
        chk("rl_valid_e5", int'(rk_valid), 1);
        chk("rl_out_e5", int'(rk_out), 0);
        chk("rl_idx_e5", int'(rk_idx), 0);
        wait_idle("rl");

        // Async reset during expansion
        tick();
        load(KEY_A, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", int'(busy), 0);
        chk("ar_valid", int'(rk_valid), 0);
        chk("ar_out", int'(rk_out), 0);
        chk("ar_idx", int'(rk_idx), 0);
        chk("ar_last", int'(rk_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ar_no_valid", int'(rk_valid), 0);
        end
        chk("ar_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
